lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage that sits directly upstream of the byte-addressed data memory. It takes one memory request per handshake from the execute stage and decodes RISC-V funct3 into memory size and sign-extension controls.
- Aligned accesses are issued as a single memory access. Misaligned halfword/word accesses are split into sequential byte accesses, with loads reassembled and extended inside this block.
- Out-of-range and illegal-funct3 requests return a fault and never touch memory.

Parameters:
- MEM_SIZE, 1024, memory depth in bytes; the legal byte range is 0..MEM_SIZE-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  execute stage presents a request.
- req_ready  output  1  block accepts a request; high only in IDLE.
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 of the load/store.
- req_addr  input  32  effective byte address.
- req_wdata  input  32  store data; low bytes are used for SB/SH.
- req_rd  input  5  load destination register, echoed in the response.
- resp_valid  output  1  one-cycle response pulse.
- resp_data  output  32  load result (extended); 0 for stores and faults.
- resp_rd  output  5  latched req_rd.
- resp_fault  output  1  request was rejected (range or funct3).
- dmem_write_en  output  1  memory write enable.
- dmem_sign_extend  output  1  memory read sign-extend control.
- dmem_addr  output  32  memory byte address.
- dmem_write_data  output  32  memory write data.
- dmem_size  output  2  00 byte, 01 half, 10 word.
- dmem_read_data  input  32  combinational memory read data.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - resp_valid, resp_fault, resp_data, resp_rd, dmem_write_en, dmem_sign_extend, dmem_addr, dmem_write_data, dmem_size = 0.
  - Reset mid-operation aborts with no response. Store bytes already written stay written.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch all request fields and compute nbytes (1/2/4).
  - Fault conditions, either of which goes to RESP with fault = 1:
    - Illegal funct3: loads accept 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores accept 000, 001, 010.
    - Out of range: addr + nbytes > MEM_SIZE, computed with 33-bit arithmetic so wrap-around cannot pass the check.
  - Aligned (byte, halfword with addr[0] = 0, word with addr[1:0] = 0) -> ACCESS.
  - Otherwise -> SPLIT with idx = 0.
- ACCESS (one cycle):
  - dmem_addr = addr; dmem_size = funct3[1:0].
  - dmem_sign_extend = ~funct3[2] for loads, 0 for stores.
  - dmem_write_en = is_store; dmem_write_data = wdata.
  - Load: capture dmem_read_data into resp_data. Then -> RESP.
- SPLIT (nbytes cycles):
  - dmem_addr = addr + idx; dmem_size = 00; dmem_sign_extend = 0.
  - dmem_write_en = is_store; dmem_write_data = {24'd0, wdata[8*idx +: 8]}.
  - Load: dmem_read_data[7:0] is placed into assembly byte idx.
  - idx increments each cycle. On idx == nbytes-1, finish the final byte and -> RESP.
  - At RESP entry, a misaligned load is sign- or zero-extended from bit 8*nbytes-1 per funct3[2].
- RESP (one cycle):
  - resp_valid = 1 with resp_data, resp_rd, resp_fault. Then -> IDLE.
- Memory-side rules:
  - dmem_write_en is 0 in IDLE and RESP under all conditions.
  - In IDLE/RESP, dmem_addr, dmem_size, dmem_sign_extend and dmem_write_data hold 0.
  - req_ready = 0 in ACCESS, SPLIT and RESP; req_valid there is ignored (the requester holds it).
- Latency from the accept edge (cycle T): aligned resp_valid at T+2; misaligned half at T+3; misaligned word at T+5; fault at T+1.
- Throughput: back-to-back requests; a new accept is possible in the cycle after RESP.
- Faults: resp_data = 0, and no memory control asserts for that request.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> one write cycle with size 10; load resp_valid at T+2, resp_data = 0xDEADBEEF, resp_fault = 0.
- SB 0x80 @0x21, SB 0xFF @0x22, then LH @0x21 -> SPLIT 2 byte reads at 0x21/0x22; resp_data = 0xFFFFFF80 at T+3. LHU @0x21 -> 0x0000FF80.
- SW 0x11223344 @0x3 -> 4 byte writes at 0x3..0x6 with data 0x44, 0x33, 0x22, 0x11 on consecutive cycles; a subsequent LW @0x4 returns 0x00112233 (byte 0x7 previously 0).
- LW @1022 (MEM_SIZE = 1024) -> resp_fault = 1, resp_data = 0 at T+1, dmem_write_en never asserted; load funct3 = 011 and store funct3 = 100 -> same fault response.
- Misaligned SW @0x41 with rst_n pulsed low after the 2nd byte write -> outputs 0 immediately, no resp_valid, state IDLE; bytes 0x41..0x42 written, 0x43..0x44 untouched.
- Two requests with req_valid held high -> second accepted the cycle after the first RESP; req_ready low throughout the first request.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage that decodes funct3, range-checks requests and
// splits misaligned halfword/word accesses into byte accesses with load reassembly.
module lsu_ctrl #(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_fault,
  output logic        dmem_write_en,
  output logic        dmem_sign_extend,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_write_data,
  output logic [1:0]  dmem_size,
  input  logic [31:0] dmem_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;
  state_t state;
  logic is_store, zext, legal, in_range, aligned, fault;
  logic [31:0] addr, wdata, asm_q, asm_next, load_ext;
  logic [1:0] idx, last, next_idx;
  logic [2:0] nbytes;
  logic [7:0] next_byte;
  assign req_ready = state == IDLE;
  always_comb begin
    nbytes = req_funct3[1:0] == 2'd0 ? 3'd1 : req_funct3[1:0] == 2'd1 ? 3'd2 : 3'd4;
    legal = req_is_store ? req_funct3 <= 3'd2
                         : (req_funct3 <= 3'd2 || req_funct3 == 3'd4 || req_funct3 == 3'd5);
    in_range = {1'b0, req_addr} + {30'd0, nbytes} <= 33'(MEM_SIZE);
    aligned = req_funct3[1:0] == 2'd0 || (req_funct3[1:0] == 2'd1 && !req_addr[0]) ||
              (req_funct3[1:0] == 2'd2 && req_addr[1:0] == 2'd0);
    fault = !legal || !in_range;
    next_idx = idx + 2'd1;
    next_byte = wdata[{next_idx, 3'b000} +: 8];
    asm_next = asm_q;
    asm_next[{idx, 3'b000} +: 8] = dmem_read_data[7:0];
    load_ext = last == 2'd1 ? {{16{asm_next[15] & ~zext}}, asm_next[15:0]} : asm_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_data <= '0;
      resp_rd <= '0;
      dmem_write_en <= 1'b0;
      dmem_sign_extend <= 1'b0;
      dmem_addr <= '0;
      dmem_write_data <= '0;
      dmem_size <= '0;
      is_store <= 1'b0;
      zext <= 1'b0;
      addr <= '0;
      wdata <= '0;
      asm_q <= '0;
      idx <= '0;
      last <= '0;
    end else begin
      resp_valid <= 1'b0;
      dmem_write_en <= 1'b0;
      dmem_sign_extend <= 1'b0;
      dmem_addr <= '0;
      dmem_write_data <= '0;
      dmem_size <= '0;
      case (state)
        IDLE: if (req_valid) begin
          is_store <= req_is_store;
          zext <= req_funct3[2];
          addr <= req_addr;
          wdata <= req_wdata;
          resp_rd <= req_rd;
          resp_data <= '0;
          resp_fault <= fault;
          asm_q <= '0;
          idx <= '0;
          last <= 2'(nbytes - 3'd1);
          if (fault) begin
            state <= RESP;
            resp_valid <= 1'b1;
          end else if (aligned) begin
            state <= ACCESS;
            dmem_addr <= req_addr;
            dmem_size <= req_funct3[1:0];
            dmem_sign_extend <= ~req_funct3[2] & ~req_is_store;
            dmem_write_en <= req_is_store;
            dmem_write_data <= req_wdata;
          end else begin
            state <= SPLIT;
            dmem_addr <= req_addr;
            dmem_write_en <= req_is_store;
            dmem_write_data <= {24'd0, req_wdata[7:0]};
          end
        end
        ACCESS: begin
          state <= RESP;
          resp_valid <= 1'b1;
          if (!is_store) resp_data <= dmem_read_data;
        end
        SPLIT: if (idx == last) begin
          state <= RESP;
          resp_valid <= 1'b1;
          if (!is_store) resp_data <= load_ext;
        end else begin
          idx <= next_idx;
          asm_q <= asm_next;
          dmem_addr <= addr + {30'd0, next_idx};
          dmem_write_en <= is_store;
          dmem_write_data <= {24'd0, next_byte};
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed table, corner sequences and random requests checked against
// a byte-array reference model; a separate memory model serves the DUT.
module tb_lsu_ctrl;
  logic clk, rst_n, req_valid, req_ready, req_is_store, resp_valid, resp_fault;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, resp_data, dmem_addr, dmem_write_data, dmem_read_data;
  logic [4:0] req_rd, resp_rd;
  logic dmem_write_en, dmem_sign_extend;
  logic [1:0] dmem_size;
  int nvec = 0, nerr = 0;
  bit clr = 1;
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];

  lsu_ctrl #(.MEM_SIZE(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_fault(resp_fault), .dmem_write_en(dmem_write_en),
    .dmem_sign_extend(dmem_sign_extend), .dmem_addr(dmem_addr),
    .dmem_write_data(dmem_write_data), .dmem_size(dmem_size), .dmem_read_data(dmem_read_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 1024; i++) mem[i] <= 8'd0;
    else if (dmem_write_en) begin
      mem[dmem_addr[9:0]] <= dmem_write_data[7:0];
      if (dmem_size != 2'd0) mem[dmem_addr[9:0] + 10'd1] <= dmem_write_data[15:8];
      if (dmem_size == 2'd2) begin
        mem[dmem_addr[9:0] + 10'd2] <= dmem_write_data[23:16];
        mem[dmem_addr[9:0] + 10'd3] <= dmem_write_data[31:24];
      end
    end
  end

  always_comb begin
    logic [9:0] ra;
    ra = dmem_addr[9:0];
    if (dmem_size == 2'd0)
      dmem_read_data = {{24{dmem_sign_extend & mem[ra][7]}}, mem[ra]};
    else if (dmem_size == 2'd1)
      dmem_read_data = {{16{dmem_sign_extend & mem[ra + 10'd1][7]}}, mem[ra + 10'd1], mem[ra]};
    else
      dmem_read_data = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: whole-request semantics straight from size, range and alignment rules.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] d, output logic f,
                       output int lat, output int nw);
    int n;
    bit legal;
    longint ea;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    ea = longint'({32'd0, a});
    d = 0;
    f = !legal || (ea + n > 1024);
    lat = 1;
    nw = 0;
    if (!f) begin
      lat = (ea % n == 0) ? 2 : 1 + n;
      for (int i = 0; i < n; i++)
        if (st) ref_mem[int'(ea) + i] = 8'(wd >> (8 * i));
        else d = d | (32'(ref_mem[int'(ea) + i]) << (8 * i));
      if (st) nw = (lat == 2) ? 1 : n;
      else if (n < 4 && !f3[2] && d[8 * n - 1]) d = d | ~((32'd1 << (8 * n)) - 32'd1);
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input bit hold,
                        output logic [31:0] gd, output logic gf, output int glat,
                        output int gw, output int waited);
    waited = 0; gd = 0; gf = 0; glat = 0; gw = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1;
    @(posedge clk);
    #1 if (!hold) req_valid = 0;
    for (int n = 1; n <= 8 && glat == 0; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        glat = n; gd = resp_data; gf = resp_fault;
        chk("resp_rd", 32'(resp_rd), 32'(rd));
        chk("resp_dmem_quiet", dmem_addr | dmem_write_data |
            {28'd0, dmem_write_en, dmem_sign_extend, dmem_size}, 32'd0);
      end else begin
        if (dmem_write_en) gw++;
        chk("ready_low", 32'(req_ready), 32'd0);
      end
    end
    if (glat == 0) chk("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  typedef struct {
    logic st; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
    logic [31:0] ed; logic ef; int lat; int nw;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [31:0] gd, md;
    logic gf, mf;
    int glat, gw, waited, mlat, mnw, bad;
    logic st;
    logic [2:0] f3;
    logic [31:0] a, wd;
    rst_n = 0; req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
    tbl.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0});
    tbl.push_back('{1'b1, 3'd0, 32'h21, 32'h80, 32'h0, 1'b0, 2, 1});
    tbl.push_back('{1'b1, 3'd0, 32'h22, 32'hFF, 32'h0, 1'b0, 2, 1});
    tbl.push_back('{1'b0, 3'd1, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 3'd5, 32'h21, 32'h0, 32'h0000FF80, 1'b0, 3, 0});
    tbl.push_back('{1'b1, 3'd2, 32'h3, 32'h11223344, 32'h0, 1'b0, 5, 4});
    tbl.push_back('{1'b0, 3'd2, 32'h4, 32'h0, 32'h00112233, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 3'd5, 32'h5, 32'h0, 32'h00001122, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 3'd2, 32'h5, 32'h0, 32'h00001122, 1'b0, 5, 0});
    tbl.push_back('{1'b0, 3'd2, 32'd1022, 32'h0, 32'h0, 1'b1, 1, 0});
    tbl.push_back('{1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0});
    tbl.push_back('{1'b1, 3'd4, 32'h10, 32'h12345678, 32'h0, 1'b1, 1, 0});
    tbl.push_back('{1'b0, 3'd0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 3'd4, 32'h22, 32'h0, 32'h000000FF, 1'b0, 2, 0});
    tbl.push_back('{1'b1, 3'd1, 32'd1022, 32'h0000BEEF, 32'h0, 1'b0, 2, 1});
    tbl.push_back('{1'b0, 3'd1, 32'd1022, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 3'd1, 32'd1023, 32'h0, 32'h0, 1'b1, 1, 0});
    tbl.push_back('{1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 1, 0});
    tbl.push_back('{1'b1, 3'd1, 32'h31, 32'h0000A5C3, 32'h0, 1'b0, 3, 2});
    tbl.push_back('{1'b0, 3'd1, 32'h31, 32'h0, 32'hFFFFA5C3, 1'b0, 3, 0});
    @(posedge clk);
    @(posedge clk);
    clr = 0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", resp_data | {26'd0, resp_rd, resp_valid | resp_fault}, 32'd0);
    chk("rst_dmem", dmem_addr | dmem_write_data |
        {28'd0, dmem_write_en, dmem_sign_extend, dmem_size}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) begin
      model(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, md, mf, mlat, mnw);
      do_req(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, 5'(i), 0, gd, gf, glat, gw, waited);
      chk($sformatf("tbl%0d_data", i), gd, tbl[i].ed);
      chk($sformatf("tbl%0d_fault", i), 32'(gf), 32'(tbl[i].ef));
      chk($sformatf("tbl%0d_lat", i), 32'(glat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_writes", i), 32'(gw), 32'(tbl[i].nw));
    end

    // Reset in the middle of a split store: two bytes land, the rest never do.
    @(negedge clk);
    req_is_store = 1; req_funct3 = 3'd2; req_addr = 32'h41; req_wdata = 32'hA1B2C3D4;
    req_rd = 5'd3; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp", resp_data | {26'd0, resp_rd, resp_valid | resp_fault}, 32'd0);
    chk("midrst_dmem", dmem_addr | dmem_write_data |
        {28'd0, dmem_write_en, dmem_sign_extend, dmem_size}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("midrst_b41", 32'(mem[32'h41]), 32'hD4);
    chk("midrst_b42", 32'(mem[32'h42]), 32'hC3);
    chk("midrst_b43", 32'(mem[32'h43]), 32'h0);
    chk("midrst_b44", 32'(mem[32'h44]), 32'h0);
    ref_mem[32'h41] = 8'hD4;
    ref_mem[32'h42] = 8'hC3;

    // req_valid held high across two requests: second accepted right after RESP.
    model(1, 3'd2, 32'h50, 32'hCAFEF00D, md, mf, mlat, mnw);
    do_req(1, 3'd2, 32'h50, 32'hCAFEF00D, 5'd7, 1, gd, gf, glat, gw, waited);
    chk("b2b_first_lat", 32'(glat), 32'd2);
    model(0, 3'd2, 32'h50, 32'h0, md, mf, mlat, mnw);
    do_req(0, 3'd2, 32'h50, 32'h0, 5'd8, 0, gd, gf, glat, gw, waited);
    chk("b2b_no_wait", 32'(waited), 32'd0);
    chk("b2b_second_data", gd, 32'hCAFEF00D);
    chk("b2b_second_lat", 32'(glat), 32'd2);

    for (int k = 0; k < 200; k++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8)
        f3 = st ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 1) % 5 + ($urandom_range(0, 1) * 0));
      else
        f3 = 3'($urandom_range(0, 7));
      if (!st && f3 == 3'd3) f3 = 3'd4;
      case ($urandom_range(0, 9))
        7, 8: a = 32'($urandom_range(1016, 1023));
        9: a = $urandom;
        default: a = 32'($urandom_range(0, 95));
      endcase
      wd = $urandom;
      model(st, f3, a, wd, md, mf, mlat, mnw);
      do_req(st, f3, a, wd, 5'($urandom_range(0, 31)), 0, gd, gf, glat, gw, waited);
      chk("rnd_data", gd, md);
      chk("rnd_fault", 32'(gf), 32'(mf));
      chk("rnd_lat", 32'(glat), 32'(mlat));
      chk("rnd_writes", 32'(gw), 32'(mnw));
    end

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final_diff_bytes", 32'(bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
